grant_scheduler: RTL
====================

GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 en  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-006 gnt_valid  output  1  a grant is active this cycle.
REQ-007 gnt_idx  output  3  binary index of the granted requester; 0 when gnt_valid=0.
REQ-008 gnt_onehot  output  8  one-hot grant, equal to the 3-to-8 decode of gnt_idx gated by gnt_valid; all-zero when gnt_valid=0.
REQ-009 preempt  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 State machine with states IDLE, BUSY and GAP; all outputs are registered or decoded from registers only.
REQ-011 IDLE: if en=1 and req!=0, select the first asserted bit searching upward from (last+1) mod 8 with wrap 7->0, load gnt_idx, clear hold counter, and enter BUSY on the same edge.
REQ-012 IDLE with en=0 or req=0: remain in IDLE; gnt_valid=0.
REQ-013 Grant latency: req sampled high in IDLE at edge k means gnt_valid=1 from edge k onward (one registered cycle).
REQ-014 BUSY: gnt_valid=1; the hold counter increments each cycle; en has no effect on an active grant.
REQ-015 BUSY exit on release: req[gnt_idx]=0 at an edge means enter GAP, set last=gnt_idx, and preempt stays 0.
REQ-016 BUSY exit on expiry: hold counter reaching MAX_HOLD cycles of grant, with request still high, means enter GAP, set last=gnt_idx, and pulse preempt for exactly the first GAP cycle.
REQ-017 If release and expiry coincide, the exit is treated as a release: preempt=0.
REQ-018 GAP lasts exactly one cycle with gnt_valid=0 and gnt_onehot=0, then enters IDLE unconditionally.
REQ-019 Round-robin fairness: a requester that holds req continuously is granted within 7 grants of any other requester.
REQ-020 Requests of non-granted lines during BUSY or GAP are ignored until IDLE; they are not latched.
REQ-021 The hold counter is $clog2(MAX_HOLD+1) bits wide and never wraps, because it saturates at MAX_HOLD.
REQ-022 The last pointer is 3 bits, and (last+1) wraps modulo 8.

Reset
REQ-023 While rst_n=0 at a clk edge: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, preempt=0, hold counter=0, last=7 (so that the first search starts at requester 0).
REQ-024 Reset asserted in BUSY or GAP aborts the grant at that edge with no preempt pulse; the first post-reset grant follows REQ-011.
REQ-025 req and en are ignored while rst_n=0.

Structure
REQ-026 A shared package holds the state enum (IDLE, BUSY, GAP), NUM_REQ=8, and IDX_W=3.
REQ-027 gnt_onehot is produced by instantiating the existing 3-to-8 decoder module Deco on gnt_idx, with its output ANDed with gnt_valid; no other sub-module is used.
REQ-028 The round-robin search is a combinational function inside grant_scheduler; no multi-cycle search is permitted.

Verification
REQ-029 Reset then req=8'h00 for 10 cycles -> gnt_valid=0, gnt_onehot=0, preempt=0 throughout.
REQ-030 After reset, req=8'h81 held -> first grant idx 0 (onehot 8'h01); after release of bit 0 and one GAP cycle -> idx 7 (onehot 8'h80).
REQ-031 MAX_HOLD=4, req=8'h04 held constantly -> grant idx 2 for 4 cycles, 1 GAP cycle with preempt=1, then re-grant idx 2.
REQ-032 req=8'hFF, each grantee drops its bit after 2 cycles -> grant order 0,1,2,...,7,0 with exactly one GAP cycle between grants.
REQ-033 en=0 with req=8'h10 -> no grant; en=1 -> idx 4 the next cycle; en toggled low during BUSY -> grant retained.
REQ-034 rst_n pulsed low mid-BUSY on idx 5 -> next cycle gnt_valid=0, preempt=0, last=7; req=8'h60 afterward -> idx 5 granted first.

Source files
------------

// File: rtl/grant_scheduler_pkg.sv
// Shared types and sizes for the round-robin grant scheduler.
package grant_scheduler_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/grant_scheduler_deco.sv
// Plain 3-to-8 binary decoder used to build the one-hot grant.
module Deco (
    input  logic [2:0] a,
    output logic [7:0] y
);

    assign y = 8'b1 << a;

endmodule

// File: rtl/grant_scheduler.sv
// Single-grant round-robin scheduler over 8 requesters with a hold limit;
// every grant is followed by one dead GAP cycle before re-arbitration.
module grant_scheduler
    import grant_scheduler_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       preempt
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               preempt_q, preempt_d;

    logic [IDX_W:0]     search;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [7:0]         deco_y;

    // First asserted request strictly after `last`, wrapping 7->0; MSB = found.
    function automatic logic [IDX_W:0] rr_search(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic             hit;
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        hit = 1'b0;
        sel = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!hit && r[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        return {hit, sel};
    endfunction

    assign search = rr_search(req, last_q);
    assign found  = search[IDX_W];
    assign pick   = search[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = BUSY;
                    idx_d   = pick;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (hold_q != HOLD_W'(MAX_HOLD))
                    hold_d = hold_q + 1'b1;
                // Release wins over expiry, so it is tested first.
                if (!req[idx_q]) begin
                    state_d = GAP;
                    last_d  = idx_q;
                    idx_d   = '0;
                end else if (hold_q >= HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = GAP;
                    last_d    = idx_q;
                    idx_d     = '0;
                    preempt_d = 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= '1;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    Deco u_deco (
        .a (idx_q),
        .y (deco_y)
    );

    assign gnt_valid  = (state_q == BUSY);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = deco_y & {8{gnt_valid}};
    assign preempt    = preempt_q;

endmodule
